// File: rtl/paj7620_i2c_target_if.sv
// Register-side strobe bus between the PAJ7620 I2C target and the register storage behind it.
// Signal directions in the names are from the target's point of view.
interface paj7620_i2c_target_if;
  logic [7:0] Reg_Addr_o;
  logic [7:0] Reg_Wdata_o;
  logic       Reg_Wr_o;
  logic       Reg_Rd_o;
  logic [7:0] Reg_Rdata_i;

  modport slave  (output Reg_Addr_o, Reg_Wdata_o, Reg_Wr_o, Reg_Rd_o, input  Reg_Rdata_i);
  modport master (input  Reg_Addr_o, Reg_Wdata_o, Reg_Wr_o, Reg_Rd_o, output Reg_Rdata_i);
endinterface

// File: rtl/paj7620_i2c_target.sv
// I2C responder emulating the PAJ7620 gesture sensor: bus decode, ACK generation and an 8-bit
// register pointer. Register contents live outside, reached through one-cycle strobes.
module paj7620_i2c_target #(
  parameter logic [6:0] DEVICE_ADDR_P = 7'h73,
  parameter int         SYNC_STAGES_P = 2
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 SCL_i,
  inout  wire                  SDA_io,
  paj7620_i2c_target_if.slave  RegBus,
  output logic                 Busy_o,
  output logic                 Debug_o
);

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_MACK,
    WAIT_STOP
  } state_e;

  logic [SYNC_STAGES_P-1:0] sclSync_q, sdaSync_q;
  logic                     sclPrev_q, sdaPrev_q;
  logic                     sclNow, sdaNow;
  logic                     sclRise, sclFall, startDet, stopDet;

  state_e     state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rw_q, rw_d;
  logic       sdaLow_q, sdaLow_d;
  logic       busy_q, busy_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       rdLoad_q, rdLoad_d;

  // The idle bus is high, so the synchronizers reset to 1 to avoid a false edge at release.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclSync_q <= {sclSync_q[SYNC_STAGES_P-2:0], SCL_i};
      sdaSync_q <= {sdaSync_q[SYNC_STAGES_P-2:0], SDA_io};
      sclPrev_q <= sclNow;
      sdaPrev_q <= sdaNow;
    end
  end

  assign sclNow   = sclSync_q[SYNC_STAGES_P-1];
  assign sdaNow   = sdaSync_q[SYNC_STAGES_P-1];
  assign sclRise  = sclNow & ~sclPrev_q;
  assign sclFall  = ~sclNow & sclPrev_q;
  assign startDet = sclNow & sclPrev_q & sdaPrev_q & ~sdaNow;
  assign stopDet  = sclNow & sclPrev_q & ~sdaPrev_q & sdaNow;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q  <= IDLE;
      bitCnt_q <= 4'd0;
      shift_q  <= 8'h00;
      ptr_q    <= 8'h00;
      wdata_q  <= 8'h00;
      rw_q     <= 1'b0;
      sdaLow_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rdLoad_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      sdaLow_q <= sdaLow_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      rdLoad_q <= rdLoad_d;
    end
  end

  // Pointer bumps the cycle after a write strobe; read data lands the cycle after the read strobe.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    sdaLow_d = sdaLow_q;
    busy_d   = busy_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    rdLoad_d = rd_q;

    if (wr_q) ptr_d = ptr_q + 8'd1;
    if (rdLoad_q) shift_d = RegBus.Reg_Rdata_i;

    if (stopDet) begin
      state_d  = IDLE;
      sdaLow_d = 1'b0;
      busy_d   = 1'b0;
      bitCnt_d = 4'd0;
    end else if (startDet) begin
      state_d  = DEV_ADDR;
      sdaLow_d = 1'b0;
      bitCnt_d = 4'd0;
    end else begin
      case (state_q)
        DEV_ADDR, REG_ADDR, WR_DATA: begin
          if (sclRise) begin
            shift_d  = {shift_q[6:0], sdaNow};
            bitCnt_d = bitCnt_q + 4'd1;
            if (state_q == WR_DATA && bitCnt_q == 4'd7) wdata_d = {shift_q[6:0], sdaNow};
          end else if (sclFall && bitCnt_q == 4'd8) begin
            bitCnt_d = 4'd0;
            if (state_q == DEV_ADDR) begin
              if (shift_q[7:1] == DEVICE_ADDR_P) begin
                state_d  = DEV_ACK;
                sdaLow_d = 1'b1;
                busy_d   = 1'b1;
                rw_d     = shift_q[0];
                rd_d     = shift_q[0];
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end else if (state_q == REG_ADDR) begin
              ptr_d    = shift_q;
              sdaLow_d = 1'b1;
              state_d  = REG_ACK;
            end else begin
              wr_d     = 1'b1;
              sdaLow_d = 1'b1;
              state_d  = WR_ACK;
            end
          end
        end
        DEV_ACK: begin
          if (sclFall) begin
            if (rw_q) begin
              // The fall that ends the address ACK already carries read bit 7.
              state_d  = RD_DATA;
              sdaLow_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b1};
              bitCnt_d = 4'd1;
            end else begin
              state_d  = REG_ADDR;
              sdaLow_d = 1'b0;
              bitCnt_d = 4'd0;
            end
          end
        end
        REG_ACK, WR_ACK: begin
          if (sclFall) begin
            state_d  = WR_DATA;
            sdaLow_d = 1'b0;
            bitCnt_d = 4'd0;
          end
        end
        RD_DATA: begin
          if (sclFall) begin
            if (bitCnt_q < 4'd8) begin
              sdaLow_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b1};
              bitCnt_d = bitCnt_q + 4'd1;
            end else begin
              sdaLow_d = 1'b0;
              state_d  = RD_MACK;
              bitCnt_d = 4'd0;
            end
          end
        end
        RD_MACK: begin
          if (sclRise) begin
            ptr_d    = ptr_q + 8'd1;
            bitCnt_d = 4'd0;
            if (!sdaNow) begin
              rd_d    = 1'b1;
              state_d = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: begin
          sdaLow_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sdaLow_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    RegBus.Reg_Addr_o  = ptr_q;
    RegBus.Reg_Wdata_o = wdata_q;
    RegBus.Reg_Wr_o    = wr_q;
    RegBus.Reg_Rd_o    = rd_q;
    Busy_o             = busy_q;
    Debug_o            = sdaLow_q;
  end

  assign SDA_io = sdaLow_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_paj7620_i2c_target.sv
// Bench for the PAJ7620 I2C target: a bit-banged I2C initiator, an array-backed register file
// and a byte-level model of pointer/strobe behaviour with randomized write/read-back traffic.
module tb_paj7620_i2c_target;
  localparam int Q = 8;

  logic Clk_i = 1'b0;
  logic Reset_i;
  logic sclDrv;
  logic tbSdaLow;
  wire  sdaLine;
  logic busy;
  logic debug;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] tbMem  [256];
  logic [7:0] expMem [256];
  logic [7:0] modelPtr;
  logic [7:0] wrAddrQ[$];
  logic [7:0] wrDataQ[$];
  logic [7:0] rdAddrQ[$];
  int overlapCount = 0;
  int dutLowCount  = 0;

  paj7620_i2c_target_if regBus();

  assign sdaLine = tbSdaLow ? 1'b0 : 1'bz;
  pullup (sdaLine);
  assign regBus.Reg_Rdata_i = tbMem[regBus.Reg_Addr_o];

  paj7620_i2c_target #(.DEVICE_ADDR_P(7'h73), .SYNC_STAGES_P(2)) dut (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .SCL_i   (sclDrv),
    .SDA_io  (sdaLine),
    .RegBus  (regBus),
    .Busy_o  (busy),
    .Debug_o (debug)
  );

  always #5 Clk_i = ~Clk_i;

  // Strobe recorder: sampled mid-cycle so each one-cycle pulse is seen exactly once.
  always @(negedge Clk_i) begin
    if (Reset_i === 1'b1) begin
      if (regBus.Reg_Wr_o) begin
        wrAddrQ.push_back(regBus.Reg_Addr_o);
        wrDataQ.push_back(regBus.Reg_Wdata_o);
      end
      if (regBus.Reg_Rd_o) rdAddrQ.push_back(regBus.Reg_Addr_o);
      if (regBus.Reg_Wr_o && regBus.Reg_Rd_o) overlapCount++;
    end
  end

  always @(posedge Clk_i) begin
    if (Reset_i === 1'b1 && !tbSdaLow && sdaLine === 1'b0) dutLowCount++;
  end

  initial begin
    repeat (80000) @(posedge Clk_i);
    $display("[TB] FAIL watchdog: simulation still running after 80000 cycles, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge Clk_i);
  endtask

  task automatic bitCycle(input logic txBit, output logic rxBit);
    tbSdaLow = !txBit;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q);
    rxBit = sdaLine;
    waitClk(Q);
    sclDrv = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStart;
    tbSdaLow = 1'b0;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q);
    tbSdaLow = 1'b1;
    waitClk(Q);
    sclDrv = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStop;
    tbSdaLow = 1'b1;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q);
    tbSdaLow = 1'b0;
    waitClk(Q);
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitCycle(d[i], r);
    bitCycle(1'b1, r);
    ack = !r;
  endtask

  task automatic readByte(input logic mAck, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitCycle(1'b1, r);
      d[i] = r;
    end
    bitCycle(!mAck, r);
  endtask

  task automatic test_reset;
    Reset_i  = 1'b0;
    sclDrv   = 1'b1;
    tbSdaLow = 1'b0;
    waitClk(4);
    assertCount++;
    if (regBus.Reg_Addr_o !== 8'h00) begin failCount++; $display("[TB] FAIL reset_addr: got %h expected 00", regBus.Reg_Addr_o); end
    assertCount++;
    if (regBus.Reg_Wdata_o !== 8'h00) begin failCount++; $display("[TB] FAIL reset_wdata: got %h expected 00", regBus.Reg_Wdata_o); end
    assertCount++;
    if ({regBus.Reg_Wr_o, regBus.Reg_Rd_o} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_strobes: got %b expected 00", {regBus.Reg_Wr_o, regBus.Reg_Rd_o}); end
    assertCount++;
    if ({busy, debug} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_busy_debug: got %b expected 00", {busy, debug}); end
    assertCount++;
    if (sdaLine !== 1'b1) begin failCount++; $display("[TB] FAIL reset_sda: got %b expected 1 (released)", sdaLine); end
    Reset_i = 1'b1;
    waitClk(4);
    modelPtr = 8'h00;
  endtask

  task automatic test_write;
    logic [2:0] acks;
    int wb;
    wb = wrAddrQ.size();
    i2cStart;
    writeByte(8'hE6, acks[2]);
    writeByte(8'h43, acks[1]);
    writeByte(8'h5A, acks[0]);
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    i2cStop;
    waitClk(4);
    modelPtr = 8'h44;
    assertCount++;
    if (acks !== 3'b111) begin failCount++; $display("[TB] FAIL write_acks: got %b expected 111", acks); end
    assertCount++;
    if (wrAddrQ.size() != wb + 1 || wrAddrQ[wb] !== 8'h43 || wrDataQ[wb] !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL write_strobe: got %0d strobes, first addr %h data %h, expected 1 strobe 43:5A",
               wrAddrQ.size() - wb, wrAddrQ[wb], wrDataQ[wb]);
    end
    assertCount++;
    if (regBus.Reg_Addr_o !== modelPtr) begin failCount++; $display("[TB] FAIL write_ptr: got %h expected %h", regBus.Reg_Addr_o, modelPtr); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL write_busy_after_stop: got %b expected 0", busy); end
  endtask

  task automatic test_read_nack;
    logic [2:0] acks;
    logic [7:0] d;
    int rb, wb;
    tbMem[8'h43] = 8'h01;
    rb = rdAddrQ.size();
    wb = wrAddrQ.size();
    i2cStart;
    writeByte(8'hE6, acks[2]);
    writeByte(8'h43, acks[1]);
    i2cStart;
    writeByte(8'hE7, acks[0]);
    readByte(1'b0, d);
    assertCount++;
    if (sdaLine !== 1'b1 || debug !== 1'b0) begin failCount++; $display("[TB] FAIL read_nack_release: got sda %b debug %b expected 1 0", sdaLine, debug); end
    i2cStop;
    waitClk(4);
    assertCount++;
    if (acks !== 3'b111) begin failCount++; $display("[TB] FAIL read_acks: got %b expected 111", acks); end
    assertCount++;
    if (d !== 8'h01) begin failCount++; $display("[TB] FAIL read_byte: got %h expected 01", d); end
    assertCount++;
    if (rdAddrQ.size() != rb + 1 || rdAddrQ[rb] !== 8'h43) begin
      failCount++;
      $display("[TB] FAIL read_strobe: got %0d reads first addr %h, expected 1 read at 43", rdAddrQ.size() - rb, rdAddrQ[rb]);
    end
    assertCount++;
    if (wrAddrQ.size() != wb) begin failCount++; $display("[TB] FAIL read_no_write: got %0d writes expected 0", wrAddrQ.size() - wb); end
    modelPtr = 8'h44;
  endtask

  task automatic test_burst_read;
    logic [7:0] d [3];
    logic [7:0] expD [3];
    logic a;
    int rb;
    expD[0] = 8'h10; expD[1] = 8'h20; expD[2] = 8'h30;
    for (int k = 0; k < 3; k++) tbMem[8'h43 + 8'(k)] = expD[k];
    rb = rdAddrQ.size();
    i2cStart;
    writeByte(8'hE6, a);
    writeByte(8'h43, a);
    i2cStart;
    writeByte(8'hE7, a);
    readByte(1'b1, d[0]);
    readByte(1'b1, d[1]);
    readByte(1'b0, d[2]);
    i2cStop;
    waitClk(4);
    modelPtr = 8'h43 + 8'd3;
    for (int k = 0; k < 3; k++) begin
      assertCount++;
      if (d[k] !== expD[k]) begin failCount++; $display("[TB] FAIL burst_byte%0d: got %h expected %h", k, d[k], expD[k]); end
    end
    assertCount++;
    if (rdAddrQ.size() != rb + 3) begin
      failCount++;
      $display("[TB] FAIL burst_read_count: got %0d expected 3", rdAddrQ.size() - rb);
    end else begin
      for (int k = 0; k < 3; k++) begin
        assertCount++;
        if (rdAddrQ[rb + k] !== 8'h43 + 8'(k)) begin failCount++; $display("[TB] FAIL burst_read_addr%0d: got %h expected %h", k, rdAddrQ[rb + k], 8'h43 + 8'(k)); end
      end
    end
    assertCount++;
    if (regBus.Reg_Addr_o !== modelPtr) begin failCount++; $display("[TB] FAIL burst_ptr: got %h expected %h", regBus.Reg_Addr_o, modelPtr); end
  endtask

  task automatic test_wrong_addr;
    logic [1:0] nacks;
    logic [2:0] acks;
    int wb, rb, lowBefore;
    wb = wrAddrQ.size();
    rb = rdAddrQ.size();
    lowBefore = dutLowCount;
    i2cStart;
    writeByte(8'hE4, nacks[1]);
    writeByte(8'h12, nacks[0]);
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL wrong_busy: got %b expected 0", busy); end
    i2cStop;
    waitClk(4);
    assertCount++;
    if (nacks !== 2'b00) begin failCount++; $display("[TB] FAIL wrong_ack: got %b expected 00", nacks); end
    assertCount++;
    if (dutLowCount != lowBefore) begin failCount++; $display("[TB] FAIL wrong_sda_low: got %0d low cycles expected 0", dutLowCount - lowBefore); end
    assertCount++;
    if (wrAddrQ.size() != wb || rdAddrQ.size() != rb) begin failCount++; $display("[TB] FAIL wrong_strobes: got %0d/%0d expected 0/0", wrAddrQ.size() - wb, rdAddrQ.size() - rb); end
    i2cStart;
    writeByte(8'hE6, acks[2]);
    writeByte(8'h43, acks[1]);
    writeByte(8'h77, acks[0]);
    i2cStop;
    waitClk(4);
    modelPtr = 8'h44;
    assertCount++;
    if (acks !== 3'b111) begin failCount++; $display("[TB] FAIL wrong_then_right_acks: got %b expected 111", acks); end
    assertCount++;
    if (wrAddrQ.size() != wb + 1 || wrDataQ[wb] !== 8'h77) begin failCount++; $display("[TB] FAIL wrong_then_right_strobe: got %0d strobes data %h expected 1 with 77", wrAddrQ.size() - wb, wrDataQ[wb]); end
  endtask

  task automatic test_wrap;
    logic [3:0] acks;
    int wb;
    wb = wrAddrQ.size();
    i2cStart;
    writeByte(8'hE6, acks[3]);
    writeByte(8'hFF, acks[2]);
    writeByte(8'hAA, acks[1]);
    writeByte(8'hBB, acks[0]);
    i2cStop;
    waitClk(4);
    modelPtr = 8'hFF + 8'd2;
    assertCount++;
    if (acks !== 4'b1111) begin failCount++; $display("[TB] FAIL wrap_acks: got %b expected 1111", acks); end
    assertCount++;
    if (wrAddrQ.size() != wb + 2 || wrAddrQ[wb] !== 8'hFF || wrAddrQ[wb + 1] !== 8'h00 ||
        wrDataQ[wb] !== 8'hAA || wrDataQ[wb + 1] !== 8'hBB) begin
      failCount++;
      $display("[TB] FAIL wrap_strobes: got %0d strobes %h:%h %h:%h expected FF:AA 00:BB",
               wrAddrQ.size() - wb, wrAddrQ[wb], wrDataQ[wb], wrAddrQ[wb + 1], wrDataQ[wb + 1]);
    end
    assertCount++;
    if (regBus.Reg_Addr_o !== modelPtr) begin failCount++; $display("[TB] FAIL wrap_ptr: got %h expected %h", regBus.Reg_Addr_o, modelPtr); end
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 4; it++) begin
      logic [7:0] base;
      logic [7:0] d;
      logic [7:0] got;
      logic [7:0] idx;
      logic a;
      int n, ackCnt, wb, rb;
      base = 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 3));
      wb = wrAddrQ.size();
      ackCnt = 0;
      i2cStart;
      writeByte(8'hE6, a); if (a) ackCnt++;
      writeByte(base, a);  if (a) ackCnt++;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        idx = base + 8'(k);
        expMem[idx] = d;
        writeByte(d, a); if (a) ackCnt++;
      end
      i2cStop;
      waitClk(4);
      modelPtr = base + 8'(n);
      assertCount++;
      if (ackCnt != n + 2) begin failCount++; $display("[TB] FAIL rnd%0d_write_acks: got %0d expected %0d", it, ackCnt, n + 2); end
      assertCount++;
      if (wrAddrQ.size() != wb + n) begin
        failCount++;
        $display("[TB] FAIL rnd%0d_write_count: got %0d expected %0d", it, wrAddrQ.size() - wb, n);
      end else begin
        for (int k = 0; k < n; k++) begin
          idx = base + 8'(k);
          assertCount++;
          if (wrAddrQ[wb + k] !== idx || wrDataQ[wb + k] !== expMem[idx]) begin
            failCount++;
            $display("[TB] FAIL rnd%0d_write%0d: got %h:%h expected %h:%h", it, k, wrAddrQ[wb + k], wrDataQ[wb + k], idx, expMem[idx]);
          end
          tbMem[idx] = wrDataQ[wb + k];
        end
      end
      assertCount++;
      if (regBus.Reg_Addr_o !== modelPtr) begin failCount++; $display("[TB] FAIL rnd%0d_write_ptr: got %h expected %h", it, regBus.Reg_Addr_o, modelPtr); end

      rb = rdAddrQ.size();
      i2cStart;
      writeByte(8'hE6, a);
      writeByte(base, a);
      i2cStart;
      writeByte(8'hE7, a);
      for (int k = 0; k < n; k++) begin
        idx = base + 8'(k);
        readByte(k != n - 1, got);
        assertCount++;
        if (got !== expMem[idx]) begin failCount++; $display("[TB] FAIL rnd%0d_read%0d: got %h expected %h", it, k, got, expMem[idx]); end
      end
      i2cStop;
      waitClk(4);
      modelPtr = base + 8'(n);
      assertCount++;
      if (rdAddrQ.size() != rb + n) begin failCount++; $display("[TB] FAIL rnd%0d_read_count: got %0d expected %0d", it, rdAddrQ.size() - rb, n); end
      assertCount++;
      if (regBus.Reg_Addr_o !== modelPtr) begin failCount++; $display("[TB] FAIL rnd%0d_read_ptr: got %h expected %h", it, regBus.Reg_Addr_o, modelPtr); end
    end
  endtask

  task automatic test_reset_midread;
    logic a;
    logic r;
    logic [2:0] acks;
    int wb;
    tbMem[8'h43] = 8'h00;
    i2cStart;
    writeByte(8'hE6, a);
    writeByte(8'h43, a);
    i2cStart;
    writeByte(8'hE7, a);
    for (int k = 0; k < 3; k++) bitCycle(1'b1, r);
    tbSdaLow = 1'b0;
    waitClk(Q);
    sclDrv = 1'b1;
    waitClk(Q / 2);
    assertCount++;
    if (sdaLine !== 1'b0) begin failCount++; $display("[TB] FAIL midread_bit4_low: got %b expected 0", sdaLine); end
    Reset_i = 1'b0;
    #1;
    assertCount++;
    if (sdaLine !== 1'b1 || debug !== 1'b0) begin failCount++; $display("[TB] FAIL midread_reset_sda: got sda %b debug %b expected 1 0", sdaLine, debug); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL midread_reset_busy: got %b expected 0", busy); end
    waitClk(3);
    Reset_i = 1'b1;
    waitClk(Q);
    wb = wrAddrQ.size();
    i2cStart;
    writeByte(8'hE6, acks[2]);
    writeByte(8'h43, acks[1]);
    writeByte(8'hC3, acks[0]);
    i2cStop;
    waitClk(4);
    modelPtr = 8'h44;
    assertCount++;
    if (acks !== 3'b111) begin failCount++; $display("[TB] FAIL midread_fresh_acks: got %b expected 111", acks); end
    assertCount++;
    if (wrAddrQ.size() != wb + 1 || wrAddrQ[wb] !== 8'h43 || wrDataQ[wb] !== 8'hC3) begin
      failCount++;
      $display("[TB] FAIL midread_fresh_strobe: got %0d strobes %h:%h expected 1 at 43:C3", wrAddrQ.size() - wb, wrAddrQ[wb], wrDataQ[wb]);
    end
    assertCount++;
    if (regBus.Reg_Addr_o !== modelPtr) begin failCount++; $display("[TB] FAIL midread_fresh_ptr: got %h expected %h", regBus.Reg_Addr_o, modelPtr); end
  endtask

  task automatic test_strobe_exclusive;
    assertCount++;
    if (overlapCount != 0) begin failCount++; $display("[TB] FAIL strobe_overlap: got %0d overlapping cycles expected 0", overlapCount); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbMem[i]  = 8'h00;
      expMem[i] = 8'h00;
    end
    test_reset;
    test_write;
    test_read_nack;
    test_burst_read;
    test_wrong_addr;
    test_wrap;
    test_back_to_back;
    test_reset_midread;
    test_strobe_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
